// File: rtl/user_locked_read_port.sv
// user_locked_read_port: returns the protected register only to READ_ID; counts denials and locks out repeat offenders
module user_locked_read_port #(
    parameter int WIDTH = 8,
    parameter logic [1:0] READ_ID = 2'h2,
    parameter int MAX_FAILS = 3,
    parameter int LOCK_CYCLES = 16,
    localparam int FW = $clog2(MAX_FAILS + 1),
    localparam int LW = $clog2(LOCK_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       usr_id,
    input  logic             rd_req,
    input  logic [WIDTH-1:0] reg_data,
    output logic             rd_busy,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             locked,
    output logic [FW-1:0]    fail_cnt
);
    typedef enum logic [1:0] {IDLE, RESP, LOCKED} state_t;
    state_t state;
    logic [LW-1:0] lock_cnt;
    logic [FW-1:0] fail_nxt;
    assign fail_nxt = (fail_cnt == FW'(MAX_FAILS)) ? fail_cnt : fail_cnt + 1'b1;
    // rd_busy stays high for one IDLE cycle after lockout so it falls the cycle after locked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_busy   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            locked    <= 1'b0;
            fail_cnt  <= '0;
            lock_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_busy) begin
                        rd_busy <= 1'b0;
                    end else if (rd_req) begin
                        state     <= RESP;
                        rd_busy   <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= (usr_id == READ_ID) ? reg_data : '0;
                        rsp_err   <= usr_id != READ_ID;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b0;
                        fail_cnt  <= rsp_err ? fail_nxt : '0;
                        if (rsp_err && fail_nxt == FW'(MAX_FAILS)) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            lock_cnt <= LW'(LOCK_CYCLES);
                        end else begin
                            state   <= IDLE;
                            rd_busy <= 1'b0;
                        end
                    end
                end
                LOCKED: begin
                    lock_cnt <= lock_cnt - 1'b1;
                    if (lock_cnt == LW'(1)) begin
                        state    <= IDLE;
                        locked   <= 1'b0;
                        fail_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_user_locked_read_port.sv
// tb_user_locked_read_port: scenario tasks checked against a transaction-level model of the read port
module tb_user_locked_read_port;
    localparam int MF = 3;
    localparam int LC = 16;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] usr_id = '0;
    logic       rd_req = 1'b0;
    logic [7:0] reg_data = '0;
    logic       rsp_ready = 1'b0;
    logic       rd_busy, rsp_valid, rsp_err, locked;
    logic [7:0] rsp_data;
    logic [1:0] fail_cnt;
    int checks = 0;
    int errors = 0;
    int m_fc = 0;

    user_locked_read_port dut (
        .clk(clk), .rst_n(rst_n), .usr_id(usr_id), .rd_req(rd_req), .reg_data(reg_data),
        .rd_busy(rd_busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .locked(locked), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_data(input logic [1:0] id, input logic [7:0] data);
        return (id == 2'h2) ? data : 8'h00;
    endfunction

    task automatic model_read(input logic [1:0] id);
        m_fc = (id == 2'h2) ? 0 : ((m_fc < MF) ? m_fc + 1 : MF);
    endtask

    task automatic read_txn(input logic [1:0] id, input logic [7:0] data, input logic [7:0] data2,
                            input int stall, output logic v, output logic [7:0] d, output logic e,
                            output logic stable, output logic [1:0] fc, output logic lk,
                            output logic busy_after);
        int n = 0;
        while (rd_busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rd_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_wait rd_busy=%b required 0", rd_busy);
        end
        usr_id = id;
        reg_data = data;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        usr_id = 2'($urandom);
        reg_data = data2;
        v = rsp_valid;
        d = rsp_data;
        e = rsp_err;
        stable = 1'b1;
        repeat (stall) begin
            @(negedge clk);
            reg_data = 8'($urandom);
            if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_err !== e) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        fc = fail_cnt;
        lk = locked;
        busy_after = rd_busy;
    endtask

    task automatic test_reset();
        checks++;
        if ({rd_busy, rsp_valid, rsp_data, rsp_err, locked, fail_cnt} !== 13'h0) begin
            errors++;
            $display("FAIL reset outputs=%h required 0", {rd_busy, rsp_valid, rsp_data, rsp_err, locked, fail_cnt});
        end
        rst_n = 1'b1;
        @(negedge clk);
        m_fc = 0;
    endtask

    task automatic test_auth_read();
        logic v, e, s, lk, b;
        logic [7:0] d;
        logic [1:0] fc;
        read_txn(2'h2, 8'hA5, 8'h5A, 0, v, d, e, s, fc, lk, b);
        model_read(2'h2);
        checks++;
        if ({v, d, e} !== {1'b1, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL auth_read v=%b d=%h e=%b required 1 a5 0", v, d, e);
        end
        checks++;
        if (fc !== 2'(m_fc)) begin
            errors++;
            $display("FAIL auth_fail_cnt got %0d required %0d", fc, m_fc);
        end
    endtask

    task automatic test_denied_read();
        logic v, e, s, lk, b;
        logic [7:0] d;
        logic [1:0] fc;
        read_txn(2'h1, 8'h3C, 8'hC3, 0, v, d, e, s, fc, lk, b);
        model_read(2'h1);
        checks++;
        if ({v, d, e, fc} !== {1'b1, 8'h00, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL denied_read v=%b d=%h e=%b fc=%0d required 1 00 1 1", v, d, e, fc);
        end
        read_txn(2'h2, 8'h77, 8'h88, 0, v, d, e, s, fc, lk, b);
        model_read(2'h2);
        checks++;
        if ({d, e, fc} !== {8'h77, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL denied_then_auth d=%h e=%b fc=%0d required 77 0 0", d, e, fc);
        end
    endtask

    task automatic test_lockout();
        logic v, e, s, lk, b, bad;
        logic [7:0] d;
        logic [1:0] fc;
        int n;
        for (int i = 0; i < MF; i++) begin
            read_txn(2'h3, 8'($urandom), 8'($urandom), 0, v, d, e, s, fc, lk, b);
            model_read(2'h3);
            checks++;
            if ({d, e, fc} !== {8'h00, 1'b1, 2'(m_fc)}) begin
                errors++;
                $display("FAIL lock_denial%0d d=%h e=%b fc=%0d required 00 1 %0d", i, d, e, fc, m_fc);
            end
        end
        checks++;
        if ({lk, b} !== 2'b11) begin
            errors++;
            $display("FAIL lock_entry locked=%b busy=%b required 1 1", lk, b);
        end
        usr_id = 2'h2;
        reg_data = 8'h5A;
        rd_req = 1'b1;
        n = 0;
        bad = 1'b0;
        while (locked && n < 64) begin
            if (rsp_valid || !rd_busy) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== LC) begin
            errors++;
            $display("FAIL lock_duration got %0d required %0d", n, LC);
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL lock_ignores_req got %b required 0", bad);
        end
        m_fc = 0;
        checks++;
        if ({rd_busy, fail_cnt} !== {1'b1, 2'(m_fc)}) begin
            errors++;
            $display("FAIL lock_exit busy=%b fc=%0d required 1 0", rd_busy, fail_cnt);
        end
        @(negedge clk);
        checks++;
        if ({rd_busy, rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL lock_busy_fall busy=%b valid=%b required 0 0", rd_busy, rsp_valid);
        end
        @(negedge clk);
        rd_req = 1'b0;
        checks++;
        if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL held_req v=%b d=%h e=%b required 1 5a 0", rsp_valid, rsp_data, rsp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic v, e, s, lk, b;
        logic [7:0] d;
        logic [1:0] fc;
        read_txn(2'h2, 8'h11, 8'h22, 5, v, d, e, s, fc, lk, b);
        model_read(2'h2);
        checks++;
        if ({v, d, e, s} !== {1'b1, 8'h11, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL stall v=%b d=%h e=%b stable=%b required 1 11 0 1", v, d, e, s);
        end
    endtask

    task automatic test_reset_mid();
        logic v, e, s, lk, b;
        logic [7:0] d;
        logic [1:0] fc;
        usr_id = 2'h2;
        reg_data = 8'hE7;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_busy, rsp_valid, rsp_data, rsp_err, locked, fail_cnt} !== 13'h0) begin
            errors++;
            $display("FAIL reset_in_resp outputs=%h required 0", {rd_busy, rsp_valid, rsp_data, rsp_err, locked, fail_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_fc = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL aborted_resp valid=%b required 0", rsp_valid);
        end
        for (int i = 0; i < MF; i++) begin
            read_txn(2'h0, 8'($urandom), 8'($urandom), 0, v, d, e, s, fc, lk, b);
            model_read(2'h0);
        end
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_busy, rsp_valid, rsp_data, rsp_err, locked, fail_cnt} !== 13'h0) begin
            errors++;
            $display("FAIL reset_in_lock outputs=%h required 0", {rd_busy, rsp_valid, rsp_data, rsp_err, locked, fail_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_fc = 0;
        read_txn(2'h2, 8'h9B, 8'h00, 1, v, d, e, s, fc, lk, b);
        model_read(2'h2);
        checks++;
        if ({v, d, e, fc, lk} !== {1'b1, 8'h9B, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_read v=%b d=%h e=%b fc=%0d lk=%b required 1 9b 0 0 0", v, d, e, fc, lk);
        end
    endtask

    task automatic test_no_lock_seq();
        logic [1:0] ids [5] = '{2'h1, 2'h0, 2'h2, 2'h3, 2'h1};
        int efc [5] = '{1, 2, 0, 1, 2};
        logic v, e, s, lk, b;
        logic [7:0] d;
        logic [1:0] fc;
        for (int i = 0; i < 5; i++) begin
            read_txn(ids[i], 8'($urandom), 8'($urandom), 0, v, d, e, s, fc, lk, b);
            model_read(ids[i]);
            checks++;
            if ({fc, lk} !== {2'(efc[i]), 1'b0}) begin
                errors++;
                $display("FAIL no_lock_seq%0d fc=%0d lk=%b required %0d 0", i, fc, lk, efc[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic v, e, s, lk, b;
        logic [7:0] d;
        logic [1:0] fc;
        time t0;
        t0 = $time;
        read_txn(2'h2, 8'h01, 8'h02, 0, v, d, e, s, fc, lk, b);
        model_read(2'h2);
        read_txn(2'h2, 8'h03, 8'h04, 0, v, d, e, s, fc, lk, b);
        model_read(2'h2);
        checks++;
        if (($time - t0) !== 64'd40 || d !== 8'h03) begin
            errors++;
            $display("FAIL back_to_back time=%0t d=%h required 40 03", $time - t0, d);
        end
    endtask

    task automatic test_random();
        logic v, e, s, lk, b;
        logic [7:0] d, dat;
        logic [1:0] fc, id;
        int n;
        for (int i = 0; i < 40; i++) begin
            id = ($urandom_range(0, 1) == 0) ? 2'h2 : 2'($urandom);
            dat = 8'($urandom);
            read_txn(id, dat, 8'($urandom), $urandom_range(0, 3), v, d, e, s, fc, lk, b);
            model_read(id);
            checks++;
            if ({v, d, e, s, fc, lk} !== {1'b1, exp_data(id, dat), id != 2'h2, 1'b1, 2'(m_fc), m_fc == MF}) begin
                errors++;
                $display("FAIL rand%0d v=%b d=%h e=%b s=%b fc=%0d lk=%b required 1 %h %b 1 %0d %b",
                         i, v, d, e, s, fc, lk, exp_data(id, dat), id != 2'h2, m_fc, m_fc == MF);
            end
            if (m_fc == MF) begin
                n = 0;
                while (locked && n < 64) begin
                    @(negedge clk);
                    n++;
                end
                m_fc = 0;
                checks++;
                if (n !== LC || fail_cnt !== 2'(m_fc)) begin
                    errors++;
                    $display("FAIL rand_lock%0d cycles=%0d fc=%0d required %0d 0", i, n, fail_cnt, LC);
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_auth_read();
        test_denied_read();
        test_lockout();
        test_stall();
        test_reset_mid();
        test_no_lock_seq();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
